sgn_detect_pipe: RTL and testbench
==================================

Name: sgn_detect_pipe

Overview:
- Pipelined, parametrised sign/zero detector for carry-save (redundant) operand pairs VS/VC in the CORDIC datapath.
- Resolves the exact sign and zero status of VS+VC (two's complement, mod 2^WIDTH) using a chunked carry-propagate adder, STAGES clock edges deep.
- In parallel, produces the fast windowed sign estimate used by redundant CORDIC iterations (top WIN bits only).
- Keeps a saturating count of estimate/exact disagreements for characterisation.

Parameters:
WIDTH, 16, operand width; must be divisible by STAGES.
STAGES, 2, pipeline depth and number of adder chunks (chunk width CW = WIDTH/STAGES); legal range 1..WIDTH.
WIN, 4, MSB window width for the estimated sign; legal range 2..WIDTH.
CNT_W, 8, mismatch counter width.

Ports:
clk  in  1  clock, rising-edge active
reset  in  1  asynchronous, active-high reset
data_in  in  1  valid strobe; VS/VC are sampled on a rising edge where data_in=1
VS  in  WIDTH  sum vector
VC  in  WIDTH  carry vector
data_out  out  1  result-valid pulse, one cycle per accepted operand pair
sgn  out  1  exact sign: MSB of (VS+VC) mod 2^WIDTH
sgn_est  out  1  MSB of (VS[W-1:W-WIN]+VC[W-1:W-WIN]) mod 2^WIN
zero  out  1  1 when (VS+VC) mod 2^WIDTH == 0
mism_cnt  out  CNT_W  saturating count of results with sgn != sgn_est

Behaviour:
- Reset (asynchronous, any time): all pipeline valid bits, carries, chunk-zero flags, skew registers, data_out, sgn, sgn_est, zero and mism_cnt go to 0. In-flight operands are discarded; no data_out is produced for them after reset release.
- Stage k (0..STAGES-1) adds chunk k (LSB chunk first) of VS and VC plus the carry registered by stage k-1 (carry into stage 0 = 0). The stage registers its carry-out, its chunk-zero AND-accumulated with earlier chunks, and the chunk MSB (meaningful only at the last stage).
- Upper chunks are delayed by skew registers so each chunk meets its carry. sgn_est is computed at stage 0 and delayed alongside.
- Pipeline advances every clock. There is no stall input; a valid bit travels with each operand pair.
- Latency: for operands sampled at edge E0, data_out=1 and results are updated after edge E0+STAGES-1. STAGES=1 means data_out is high in the cycle after the sampling edge.
- Throughput is one pair per clock. Back-to-back data_in highs give back-to-back data_out highs with independent results.
- data_out is high for exactly one cycle per accepted pair.
- sgn, sgn_est and zero update only when the final stage is valid, and hold their last values otherwise.
- mism_cnt increments by 1 on each final-stage valid cycle where sgn != sgn_est, and saturates at 2^CNT_W-1 (no wrap).
- Overflow of VS+VC wraps modulo 2^WIDTH; the carry-out of the top chunk is dropped.
- data_in is sampled only at the clock edge; glitches between edges have no effect.

Decomposition:
- Package sgn_detect_pkg: default WIDTH/STAGES/WIN/CNT_W constants, a function returning CW, and a typedef for the per-stage record {valid, carry, zero_acc, msb, est}.
- One sub-module: csa_chunk_add. It is a combinational CW-bit adder with carry-in that produces sum MSB, carry-out and chunk-zero. It is instantiated STAGES times in a generate loop.
- The top level owns all registers and the counter.

Test Plan:
(All with WIDTH=16, STAGES=2, WIN=4, CNT_W=8.)
1. Reset asserted mid-stream with one pair in flight -> data_out, sgn, sgn_est, zero, mism_cnt all 0 immediately. No data_out appears for the flushed pair after reset release.
2. Single pulse, VS=0x8300, VC=0x0001 -> data_out high for one cycle after the 2nd edge; sgn=1, sgn_est=1, zero=0, mism_cnt=0.
3. Back-to-back pairs (VS=0x161D, VC=0x2F0A) then (VS=0x7FFF, VC=0x0001) -> two consecutive data_out cycles. First gives sgn=0, sgn_est=0. Second gives sgn=1, sgn_est=0 (carry crosses the chunk boundary) and mism_cnt=1.
4. VS=0xFFFF, VC=0x0001 -> zero=1, sgn=0, sgn_est=1, mism_cnt increments. Outputs then hold while data_in=0 for 5 cycles, with data_out=0.
5. 300 consecutive mismatching pairs (0x7FFF/0x0001) -> mism_cnt saturates at 255 and stays there.
6. Parameter sweep STAGES=1,4,8 with random VS/VC versus a reference model -> latency equals STAGES edges, and sgn/zero/sgn_est match the model on every data_out.

Source files
------------

// File: rtl/sgn_detect_pkg.sv
// Shared constants, chunk-width helper and per-stage record for the
// pipelined carry-save sign/zero detector.
package sgn_detect_pkg;

  localparam int unsigned WIDTH_DEF  = 16;
  localparam int unsigned STAGES_DEF = 2;
  localparam int unsigned WIN_DEF    = 4;
  localparam int unsigned CNT_W_DEF  = 8;

  // Width of one adder chunk; width must be a multiple of stages.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
    logic zero_acc;
    logic msb;
    logic est;
  } stage_t;

endpackage

// File: rtl/csa_chunk_add.sv
// Combinational CW-bit chunk adder with carry-in: reports sum MSB,
// carry-out and whether the chunk sum is zero.
module csa_chunk_add #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic          msb_c,
  output logic          cout_c,
  output logic          zero_c
);

  logic [CW:0] sum;

  assign sum    = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  assign msb_c  = sum[CW-1];
  assign cout_c = sum[CW];
  assign zero_c = (sum[CW-1:0] == '0);

endmodule

// File: rtl/sgn_detect_pipe.sv
// Pipelined exact sign/zero detector for VS+VC with a parallel windowed
// sign estimate and a saturating estimate/exact disagreement counter.
module sgn_detect_pipe
  import sgn_detect_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned STAGES = STAGES_DEF,
  parameter int unsigned WIN    = WIN_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic [WIDTH-1:0] VS,
  input  logic [WIDTH-1:0] VC,
  output logic             data_out,
  output logic             sgn,
  output logic             sgn_est,
  output logic             zero,
  output logic [CNT_W-1:0] mism_cnt
);

  localparam int unsigned CW = chunk_width(WIDTH, STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Fast estimate: only the top WIN bits, carries from below ignored.
  logic [WIN-1:0] est_sum;
  logic           unused;

  assign est_sum = VS[WIDTH-1 -: WIN] + VC[WIDTH-1 -: WIN];
  assign unused  = ^est_sum[WIN-2:0];

  logic fin_valid;
  logic fin_msb;
  logic fin_zero;
  logic fin_est;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned REM = WIDTH - CW * k;

    logic [REM-1:0] vs_in;
    logic [REM-1:0] vc_in;
    logic           valid_in;
    logic           carry_in;
    logic           zacc_in;
    logic           est_in;
    logic           msb;
    logic           cout;
    logic           czero;

    if (k == 0) begin : g_head
      assign vs_in    = VS;
      assign vc_in    = VC;
      assign valid_in = data_in;
      assign carry_in = 1'b0;
      assign zacc_in  = 1'b1;
      assign est_in   = est_sum[WIN-1];
    end else begin : g_body
      assign vs_in    = g_st[k-1].g_reg.vs_q;
      assign vc_in    = g_st[k-1].g_reg.vc_q;
      assign valid_in = g_st[k-1].g_reg.rec_q.valid;
      assign carry_in = g_st[k-1].g_reg.rec_q.carry;
      assign zacc_in  = g_st[k-1].g_reg.rec_q.zero_acc;
      assign est_in   = g_st[k-1].g_reg.rec_q.est;
    end

    csa_chunk_add #(
      .CW (CW)
    ) u_add (
      .a      (vs_in[CW-1:0]),
      .b      (vc_in[CW-1:0]),
      .cin    (carry_in),
      .msb_c  (msb),
      .cout_c (cout),
      .zero_c (czero)
    );

    if (k < STAGES - 1) begin : g_reg
      stage_t              rec_d;
      stage_t              rec_q;
      logic [REM-CW-1:0]   vs_q;
      logic [REM-CW-1:0]   vc_q;
      logic                unused_msb;

      assign rec_d      = {valid_in, cout, zacc_in & czero, msb, est_in};
      assign unused_msb = rec_q.msb;

      // Stage record plus skewed upper chunks waiting for this carry.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rec_q <= '0;
          vs_q  <= '0;
          vc_q  <= '0;
        end else begin
          rec_q <= rec_d;
          vs_q  <= vs_in[REM-1:CW];
          vc_q  <= vc_in[REM-1:CW];
        end
      end
    end else begin : g_last
      // Carry out of the top chunk is the dropped mod-2^WIDTH overflow.
      logic unused_cout;

      assign unused_cout = cout;
      assign fin_valid   = valid_in;
      assign fin_msb     = msb;
      assign fin_zero    = zacc_in & czero;
      assign fin_est     = est_in;
    end
  end

  // Result registers hold their value between valid final-stage cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= 1'b0;
      sgn      <= 1'b0;
      sgn_est  <= 1'b0;
      zero     <= 1'b0;
      mism_cnt <= '0;
    end else begin
      data_out <= fin_valid;
      if (fin_valid) begin
        sgn     <= fin_msb;
        sgn_est <= fin_est;
        zero    <= fin_zero;
        if ((fin_msb != fin_est) && (mism_cnt != CNT_MAX)) begin
          mism_cnt <= mism_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sgn_detect_pipe.sv
// Scoreboarded bench for sgn_detect_pipe: STAGES=2 main instance plus
// STAGES=1/4/8 instances driven with identical stimulus.
module tb_sgn_detect_pipe;

  localparam int NDUT = 4;
  localparam int unsigned ST [NDUT] = '{2, 1, 4, 8};

  typedef struct {
    int unsigned due;
    logic        sgn;
    logic        est;
    logic        zero;
    logic [7:0]  cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            data_in;
  logic [15:0]     vs;
  logic [15:0]     vc;
  logic [NDUT-1:0] dout;
  logic [NDUT-1:0] sg;
  logic [NDUT-1:0] se;
  logic [NDUT-1:0] zr;
  logic [7:0]      mc [NDUT];

  exp_t        sb [NDUT][$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  mcnt = 8'd0;

  sgn_detect_pipe #(.WIDTH(16), .STAGES(2), .WIN(4), .CNT_W(8)) u_dut2 (
    .clk(clk), .reset(reset), .data_in(data_in), .VS(vs), .VC(vc),
    .data_out(dout[0]), .sgn(sg[0]), .sgn_est(se[0]), .zero(zr[0]), .mism_cnt(mc[0]));
  sgn_detect_pipe #(.WIDTH(16), .STAGES(1), .WIN(4), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .VS(vs), .VC(vc),
    .data_out(dout[1]), .sgn(sg[1]), .sgn_est(se[1]), .zero(zr[1]), .mism_cnt(mc[1]));
  sgn_detect_pipe #(.WIDTH(16), .STAGES(4), .WIN(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .VS(vs), .VC(vc),
    .data_out(dout[2]), .sgn(sg[2]), .sgn_est(se[2]), .zero(zr[2]), .mism_cnt(mc[2]));
  sgn_detect_pipe #(.WIDTH(16), .STAGES(8), .WIN(4), .CNT_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .data_in(data_in), .VS(vs), .VC(vc),
    .data_out(dout[3]), .sgn(sg[3]), .sgn_est(se[3]), .zero(zr[3]), .mism_cnt(mc[3]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops expected results and checks latency and values.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      for (int i = 0; i < NDUT; i++) begin
        if (dout[i] === 1'b1) begin
          n_checks++;
          if (sb[i].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out stages=%0d cyc=%0d data_out=1 required 0", ST[i], cyc);
          end else begin
            exp_t e;
            e = sb[i].pop_front();
            n_checks += 5;
            if (cyc !== e.due) begin n_fail++; $display("FAIL latency stages=%0d got cyc %0d required %0d", ST[i], cyc, e.due); end
            if (sg[i] !== e.sgn) begin n_fail++; $display("FAIL sgn stages=%0d cyc=%0d got %b required %b", ST[i], cyc, sg[i], e.sgn); end
            if (se[i] !== e.est) begin n_fail++; $display("FAIL sgn_est stages=%0d cyc=%0d got %b required %b", ST[i], cyc, se[i], e.est); end
            if (zr[i] !== e.zero) begin n_fail++; $display("FAIL zero stages=%0d cyc=%0d got %b required %b", ST[i], cyc, zr[i], e.zero); end
            if (mc[i] !== e.cnt) begin n_fail++; $display("FAIL mism_cnt stages=%0d cyc=%0d got %0d required %0d", ST[i], cyc, mc[i], e.cnt); end
          end
        end
        while (sb[i].size() > 0 && sb[i][0].due < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_out stages=%0d cyc=%0d no data_out, required at cyc %0d", ST[i], cyc, sb[i][0].due);
          void'(sb[i].pop_front());
        end
      end
    end
  end

  // Drive one pair (sampled at the next rising edge) and record expectations.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic [3:0]  t;
    exp_t        e;
    vs = a;
    vc = b;
    data_in = 1'b1;
    s = a + b;
    t = a[15:12] + b[15:12];
    e.sgn  = s[15];
    e.est  = t[3];
    e.zero = (s == 16'h0000);
    if (e.sgn != e.est && mcnt != 8'hFF) mcnt = mcnt + 8'd1;
    e.cnt = mcnt;
    for (int i = 0; i < NDUT; i++) begin
      e.due = cyc + ST[i];
      sb[i].push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    data_in = 1'b0;
    repeat (n) begin
      vs = 16'($urandom());
      vc = 16'($urandom());
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_in = 1'b0;
    vs = '0;
    vc = '0;
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (dout[0] !== 1'b0) begin n_fail++; $display("FAIL reset_data_out got %b required 0", dout[0]); end
    if (sg[0] !== 1'b0) begin n_fail++; $display("FAIL reset_sgn got %b required 0", sg[0]); end
    if (se[0] !== 1'b0) begin n_fail++; $display("FAIL reset_sgn_est got %b required 0", se[0]); end
    if (zr[0] !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b required 0", zr[0]); end
    if (mc[0] !== 8'd0) begin n_fail++; $display("FAIL reset_mism_cnt got %0d required 0", mc[0]); end
    reset = 1'b0;
    idle(3);
  endtask

  task automatic test_single();
    send(16'h8300, 16'h0001);
    data_in = 1'b0;
    n_checks++;
    if (dout[0] !== 1'b0) begin n_fail++; $display("FAIL single_early got data_out=%b required 0", dout[0]); end
    @(negedge clk);
    n_checks += 5;
    if (dout[0] !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b required 1", dout[0]); end
    if (sg[0] !== 1'b1) begin n_fail++; $display("FAIL single_sgn got %b required 1", sg[0]); end
    if (se[0] !== 1'b1) begin n_fail++; $display("FAIL single_est got %b required 1", se[0]); end
    if (zr[0] !== 1'b0) begin n_fail++; $display("FAIL single_zero got %b required 0", zr[0]); end
    if (mc[0] !== 8'd0) begin n_fail++; $display("FAIL single_cnt got %0d required 0", mc[0]); end
    @(negedge clk);
    n_checks++;
    if (dout[0] !== 1'b0) begin n_fail++; $display("FAIL single_pulse got data_out=%b required 0", dout[0]); end
    idle(10);
  endtask

  task automatic test_back_to_back();
    send(16'h161D, 16'h2F0A);
    send(16'h7FFF, 16'h0001);
    data_in = 1'b0;
    n_checks += 4;
    if (dout[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got %b required 1", dout[0]); end
    if (sg[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_first_sgn got %b required 0", sg[0]); end
    if (se[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_first_est got %b required 0", se[0]); end
    if (mc[0] !== 8'd0) begin n_fail++; $display("FAIL b2b_first_cnt got %0d required 0", mc[0]); end
    @(negedge clk);
    n_checks += 4;
    if (dout[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %b required 1", dout[0]); end
    if (sg[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_sgn got %b required 1", sg[0]); end
    if (se[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_second_est got %b required 0", se[0]); end
    if (mc[0] !== 8'd1) begin n_fail++; $display("FAIL b2b_second_cnt got %0d required 1", mc[0]); end
    @(negedge clk);
    n_checks++;
    if (dout[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_end got data_out=%b required 0", dout[0]); end
    idle(10);
  endtask

  task automatic test_zero_hold();
    send(16'hFFFF, 16'h0001);
    data_in = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      n_checks += 5;
      if (dout[0] !== (c == 0)) begin n_fail++; $display("FAIL hold_valid c=%0d got %b required %b", c, dout[0], c == 0); end
      if (zr[0] !== 1'b1) begin n_fail++; $display("FAIL hold_zero c=%0d got %b required 1", c, zr[0]); end
      if (sg[0] !== 1'b0) begin n_fail++; $display("FAIL hold_sgn c=%0d got %b required 0", c, sg[0]); end
      if (se[0] !== 1'b1) begin n_fail++; $display("FAIL hold_est c=%0d got %b required 1", c, se[0]); end
      if (mc[0] !== 8'd2) begin n_fail++; $display("FAIL hold_cnt c=%0d got %0d required 2", c, mc[0]); end
      vs = 16'($urandom());
      vc = 16'($urandom());
      @(negedge clk);
    end
    idle(8);
  endtask

  task automatic test_reset_midstream();
    send(16'h1234, 16'h0101);
    data_in = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    n_checks += 5;
    if (dout[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_data_out got %b required 0", dout[0]); end
    if (sg[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_sgn got %b required 0", sg[0]); end
    if (se[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_sgn_est got %b required 0", se[0]); end
    if (zr[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_zero got %b required 0", zr[0]); end
    if (mc[0] !== 8'd0) begin n_fail++; $display("FAIL midrst_mism_cnt got %0d required 0", mc[0]); end
    for (int i = 0; i < NDUT; i++) sb[i].delete();
    mcnt = 8'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(12);
  endtask

  task automatic test_saturate();
    repeat (300) send(16'h7FFF, 16'h0001);
    idle(12);
    for (int i = 0; i < NDUT; i++) begin
      n_checks++;
      if (mc[i] !== 8'd255) begin n_fail++; $display("FAIL saturate stages=%0d got %0d required 255", ST[i], mc[i]); end
    end
  endtask

  task automatic test_random_sweep();
    logic [15:0] a;
    logic [15:0] b;
    for (int n = 0; n < 300; n++) begin
      a = 16'($urandom());
      b = 16'($urandom());
      if (n % 7 == 0) b = -a;
      if (n % 11 == 0) b = 16'h0000;
      send(a, b);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(12);
    for (int i = 0; i < NDUT; i++) begin
      n_checks++;
      if (sb[i].size() != 0) begin n_fail++; $display("FAIL drain stages=%0d got %0d pending required 0", ST[i], sb[i].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_hold();
    test_reset_midstream();
    test_saturate();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
